gsu_reg_select: RTL

Prefix/register-select sequencer for the GSU instruction path. It consumes the fetched opcode stream and tracks prefix state: TO/FROM/WITH register selects, the B flag, and the ALT1/ALT2 mode bits. For each executing instruction it presents the effective source and destination register indices (`sreg_sel`, `dreg_sel`). `dreg_sel` feeds the 4-to-16 one-hot decoder that drives register-file write enables. Prefix state persists across prefix opcodes and clears when a non-prefix instruction completes.

---
 rtl/gsu_pkg.sv | 30 +++
 rtl/gsu_prefix_classify.sv | 37 +++
 rtl/gsu_reg_select.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gsu_pkg.sv
// ============================================================================
// Module   : gsu_pkg
// Purpose  : Opcode constants, state encoding and helpers for GSU prefix logic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gsu_pkg;

  localparam logic [7:0] OP_ALT1    = 8'h3D;
  localparam logic [7:0] OP_ALT2    = 8'h3E;
  localparam logic [7:0] OP_ALT3    = 8'h3F;
  localparam logic [3:0] OP_TO_HI   = 4'h1;
  localparam logic [3:0] OP_WITH_HI = 4'h2;
  localparam logic [3:0] OP_FROM_HI = 4'hB;
  localparam logic [7:0] OP_BRA_LO  = 8'h05;
  localparam logic [7:0] OP_BRA_HI  = 8'h0F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  function automatic logic is_branch_op(input logic [7:0] op);
    return (op >= OP_BRA_LO) && (op <= OP_BRA_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gsu_prefix_classify.sv
// ============================================================================
// Module   : gsu_prefix_classify
// Purpose  : Combinational decode of {opcode, B} into prefix/move/branch class
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gsu_prefix_classify
  import gsu_pkg::*;
(
  input  logic [7:0] op,
  input  logic       b,
  output logic       is_prefix,
  output logic       is_move,
  output logic       is_branch,
  output logic [3:0] nibble
);

  logic w_is_alt;
  logic w_is_to;
  logic w_is_with;
  logic w_is_from;

  assign w_is_alt  = (op == OP_ALT1) || (op == OP_ALT2) || (op == OP_ALT3);
  assign w_is_to   = (op[7:4] == OP_TO_HI);
  assign w_is_with = (op[7:4] == OP_WITH_HI);
  assign w_is_from = (op[7:4] == OP_FROM_HI);

  // TO/FROM act as prefixes only without B; with B they become MOVE/MOVES
  assign is_prefix = w_is_alt | w_is_with | ((w_is_to | w_is_from) & ~b);
  assign is_move   = (w_is_to | w_is_from) & b;
  assign is_branch = is_branch_op(op);
  assign nibble    = op[3:0];

endmodule

`default_nettype wire

// File: rtl/gsu_reg_select.sv
// ============================================================================
// Module   : gsu_reg_select
// Purpose  : GSU prefix tracker presenting effective source/destination selects
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gsu_reg_select
  import gsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       op_valid,
  input  logic [7:0] op,
  output logic       op_ready,
  input  logic       inst_done,
  output logic       exec_valid,
  output logic [7:0] exec_op,
  output logic       exec_move,
  output logic [3:0] sreg_sel,
  output logic [3:0] dreg_sel,
  output logic       b_flag,
  output logic       alt1,
  output logic       alt2
);

  state_t     r_state;
  logic       r_exec_valid;
  logic [7:0] r_exec_op;
  logic       r_exec_move;
  logic [3:0] r_sreg;
  logic [3:0] r_dreg;
  logic       r_b;
  logic       r_alt1;
  logic       r_alt2;

  logic       w_is_prefix;
  logic       w_is_move;
  logic       w_is_branch_in;
  logic [3:0] w_nibble;
  logic       w_accept;
  logic       w_keep_prefix;

  gsu_prefix_classify u_classify (
    .op        (op),
    .b         (r_b),
    .is_prefix (w_is_prefix),
    .is_move   (w_is_move),
    .is_branch (w_is_branch_in),
    .nibble    (w_nibble)
  );

  // Ready drops combinationally with rst/go so nothing is taken during abort
  assign op_ready      = ~rst & go & (r_state == IDLE);
  assign w_accept      = op_valid & op_ready;
  assign w_keep_prefix = is_branch_op(r_exec_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_exec_valid <= 1'b0;
      r_exec_op    <= 8'h00;
      r_exec_move  <= 1'b0;
      r_sreg       <= 4'h0;
      r_dreg       <= 4'h0;
      r_b          <= 1'b0;
      r_alt1       <= 1'b0;
      r_alt2       <= 1'b0;
    end else if (!go) begin
      r_state      <= IDLE;
      r_exec_valid <= 1'b0;
      r_exec_op    <= 8'h00;
      r_exec_move  <= 1'b0;
      r_sreg       <= 4'h0;
      r_dreg       <= 4'h0;
      r_b          <= 1'b0;
      r_alt1       <= 1'b0;
      r_alt2       <= 1'b0;
    end else begin
      r_exec_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_prefix) begin
              case (op)
                OP_ALT1: r_alt1 <= 1'b1;
                OP_ALT2: r_alt2 <= 1'b1;
                OP_ALT3: begin
                  r_alt1 <= 1'b1;
                  r_alt2 <= 1'b1;
                end
                default: begin
                  if (op[7:4] == OP_WITH_HI) begin
                    r_sreg <= w_nibble;
                    r_dreg <= w_nibble;
                    r_b    <= 1'b1;
                  end else if (op[7:4] == OP_TO_HI) begin
                    r_dreg <= w_nibble;
                  end else begin
                    r_sreg <= w_nibble;
                  end
                end
              endcase
            end else begin
              r_state      <= EXEC;
              r_exec_valid <= 1'b1;
              r_exec_op    <= op;
              r_exec_move  <= w_is_move;
              // MOVE retargets dreg, MOVES retargets sreg
              if (w_is_move) begin
                if (op[7:4] == OP_TO_HI) begin
                  r_dreg <= w_nibble;
                end else begin
                  r_sreg <= w_nibble;
                end
              end
            end
          end
        end
        EXEC: begin
          if (inst_done) begin
            r_state <= IDLE;
            if (!w_keep_prefix) begin
              r_exec_move <= 1'b0;
              r_sreg      <= 4'h0;
              r_dreg      <= 4'h0;
              r_b         <= 1'b0;
              r_alt1      <= 1'b0;
              r_alt2      <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign exec_valid = r_exec_valid;
  assign exec_op    = r_exec_op;
  assign exec_move  = r_exec_move;
  assign sreg_sel   = r_sreg;
  assign dreg_sel   = r_dreg;
  assign b_flag     = r_b;
  assign alt1       = r_alt1;
  assign alt2       = r_alt2;

  logic w_unused;
  assign w_unused = w_is_branch_in;

endmodule

`default_nettype wire
